// File: rtl/fpu_fma_special.sv
// fpu_fma_special
//   Special-case resolver that runs alongside the main FMA datapath. It
//   classifies an operand set (X*Y +/- Z), decides whether the IEEE-754
//   single result is fully determined by operand classes (NaN, infinity,
//   exact zero) and, if so, produces that result and the invalid flag.
//   Two-stage valid/ready pipeline with flush.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operand-set handshake (in_ready has no path from in_valid)
//   op[1:0]                  00 FMADD, 01 FMSUB, 10 FNMSUB, 11 FNMADD
//   rm[2:0]                  RISC-V rounding mode (010 = RDN)
//   {x,y,z}s, *_zero, *_inf, *_nan, *_snan   operand sign and class flags
//   flush                    drop every in-flight entry
//   out_valid / out_ready    result handshake
//   special                  result fully determined here
//   result[31:0]             special result (0 when special=0)
//   flag_nv                  invalid-operation exception
module fpu_fma_special (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [2:0]  rm,
  input  logic        xs,
  input  logic        x_zero,
  input  logic        x_inf,
  input  logic        x_nan,
  input  logic        x_snan,
  input  logic        ys,
  input  logic        y_zero,
  input  logic        y_inf,
  input  logic        y_nan,
  input  logic        y_snan,
  input  logic        zs,
  input  logic        z_zero,
  input  logic        z_inf,
  input  logic        z_nan,
  input  logic        z_snan,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        special,
  output logic [31:0] result,
  output logic        flag_nv
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Resolved priority case carried from stage 1 to stage 2.
  typedef enum logic [2:0] {
    CASE_NONE,
    CASE_NAN_NV,   // canonical NaN, invalid raised
    CASE_NAN_Q,    // canonical NaN from quiet NaN input, no flag
    CASE_PINF,     // product infinity
    CASE_ZINF,     // addend infinity
    CASE_ZERO      // exact zero result
  } case_e;

  // Handshake
  logic s1_valid_q, out_valid_q;
  logic adv1, adv2, accept;

  // Stage 1 next-state / registers
  case_e case_d, case_q;
  logic  ps_d, za_d, zsgn_d;
  logic  ps_q, za_q, zsgn_q;

  // Stage 2 next-state / registers
  logic        special_d, special_q;
  logic [31:0] result_d, result_q;
  logic        nv_d, nv_q;

  assign adv2     = !out_valid_q | out_ready;
  assign adv1     = !s1_valid_q | adv2;
  assign in_ready = adv1 & !rst;
  assign accept   = in_valid & in_ready;

  // Stage 1: classify in strict priority order.
  always_comb begin
    logic prod_inf, prod_zero, any_nan, any_snan;
    ps_d      = xs ^ ys ^ op[1];
    za_d      = zs ^ op[0];
    // Exact zero with opposite signs takes -0 only under round-down.
    zsgn_d    = (ps_d == za_d) ? ps_d : (rm == 3'b010);
    prod_inf  = x_inf | y_inf;
    prod_zero = x_zero | y_zero;
    any_snan  = x_snan | y_snan | z_snan;
    any_nan   = x_nan | y_nan | z_nan | any_snan;
    case_d    = CASE_NONE;
    if ((x_inf & y_zero) | (x_zero & y_inf))
      case_d = CASE_NAN_NV;
    else if (any_nan)
      case_d = any_snan ? CASE_NAN_NV : CASE_NAN_Q;
    else if (prod_inf & z_inf & (ps_d != za_d))
      case_d = CASE_NAN_NV;
    else if (prod_inf)
      case_d = CASE_PINF;
    else if (z_inf)
      case_d = CASE_ZINF;
    else if (prod_zero & z_zero)
      case_d = CASE_ZERO;
  end

  // Stage 2: form the result word from the registered case.
  always_comb begin
    special_d = 1'b1;
    result_d  = '0;
    nv_d      = 1'b0;
    unique case (case_q)
      CASE_NAN_NV: begin result_d = QNAN; nv_d = 1'b1; end
      CASE_NAN_Q:  result_d = QNAN;
      CASE_PINF:   result_d = {ps_q, 8'hFF, 23'h0};
      CASE_ZINF:   result_d = {za_q, 8'hFF, 23'h0};
      CASE_ZERO:   result_d = {zsgn_q, 31'h0};
      default:     special_d = 1'b0;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      special_q   <= 1'b0;
      result_q    <= '0;
      nv_q        <= 1'b0;
    end else if (flush) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (adv1) s1_valid_q <= accept;
      if (adv2) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          special_q <= special_d;
          result_q  <= result_d;
          nv_q      <= nv_d;
        end
      end
    end
  end

  // Stage 1 payload needs no reset: it is qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    if (adv1 && accept) begin
      case_q <= case_d;
      ps_q   <= ps_d;
      za_q   <= za_d;
      zsgn_q <= zsgn_d;
    end
  end

  assign out_valid = out_valid_q;
  assign special   = special_q;
  assign result    = result_q;
  assign flag_nv   = nv_q;

endmodule

// File: tb/tb_fpu_fma_special.sv
// Self-checking bench for fpu_fma_special: directed vector table, backpressure,
// flush and reset sequences, then randomized traffic against a queue model.
module tb_fpu_fma_special;

  // Operand class packing: {sign, zero, inf, nan, snan}
  localparam logic [4:0] C_POS  = 5'b00000;
  localparam logic [4:0] C_PZ   = 5'b01000;
  localparam logic [4:0] C_NZ   = 5'b11000;
  localparam logic [4:0] C_PINF = 5'b00100;
  localparam logic [4:0] C_NINF = 5'b10100;
  localparam logic [4:0] C_QNAN = 5'b00010;
  localparam logic [4:0] C_SNAN = 5'b00011;
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [1:0] opv = '0;
  logic [2:0] rmv = '0;
  logic [4:0] xc = '0, yc = '0, zc = '0;
  logic in_ready, out_valid, special, flag_nv;
  logic [31:0] result;

  always #5 clk = ~clk;

  fpu_fma_special dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(opv), .rm(rmv),
    .xs(xc[4]), .x_zero(xc[3]), .x_inf(xc[2]), .x_nan(xc[1]), .x_snan(xc[0]),
    .ys(yc[4]), .y_zero(yc[3]), .y_inf(yc[2]), .y_nan(yc[1]), .y_snan(yc[0]),
    .zs(zc[4]), .z_zero(zc[3]), .z_inf(zc[2]), .z_nan(zc[1]), .z_snan(zc[0]),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .special(special), .result(result), .flag_nv(flag_nv)
  );

  typedef struct {
    logic        sp;
    logic [31:0] res;
    logic        nv;
    int unsigned acc;
  } ent_t;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  rm;
    logic [4:0]  x, y, z;
    logic        sp;
    logic [31:0] res;
    logic        nv;
  } vec_t;

  int tests = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int emitted = 0;
  ent_t q[$];
  logic hold_chk = 1'b0;
  logic [33:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: resolve the operand classes directly from the rules.
  function automatic ent_t model(logic [1:0] o, logic [2:0] r, logic [4:0] x, logic [4:0] y, logic [4:0] z);
    ent_t e;
    bit neg_prod = (o == 2'b10) || (o == 2'b11);
    bit neg_add  = (o == 2'b01) || (o == 2'b11);
    bit p_sign   = x[4] ^ y[4] ^ neg_prod;
    bit a_sign   = z[4] ^ neg_add;
    bit x_nan = x[1] | x[0], y_nan = y[1] | y[0], z_nan = z[1] | z[0];
    e.acc = 0;
    e.sp = 1'b1;
    e.nv = 1'b0;
    e.res = 32'h0;
    if ((x[2] && y[3]) || (x[3] && y[2])) begin
      e.res = QNAN; e.nv = 1'b1;
    end else if (x_nan || y_nan || z_nan) begin
      e.res = QNAN; e.nv = x[0] | y[0] | z[0];
    end else if ((x[2] || y[2]) && z[2] && p_sign != a_sign) begin
      e.res = QNAN; e.nv = 1'b1;
    end else if (x[2] || y[2]) begin
      e.res = p_sign ? 32'hFF80_0000 : 32'h7F80_0000;
    end else if (z[2]) begin
      e.res = a_sign ? 32'hFF80_0000 : 32'h7F80_0000;
    end else if ((x[3] || y[3]) && z[3]) begin
      if (p_sign == a_sign) e.res = p_sign ? 32'h8000_0000 : 32'h0;
      else                  e.res = (r == 3'b010) ? 32'h8000_0000 : 32'h0;
    end else begin
      e.sp = 1'b0;
    end
    return e;
  endfunction

  // One clock cycle with the current operands; checks handshake and scoreboard.
  task automatic tick(input logic iv, input logic ordy, input logic fl, output logic acc);
    ent_t e;
    logic exp_ov, exp_ir;
    in_valid = iv; out_ready = ordy; flush = fl;
    #1;
    // Two entries in flight fill both stages; a stalled output then blocks input.
    exp_ir = !(q.size() == 2 && !ordy);
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (hold_chk) chk("hold", 32'({special, flag_nv, result[29:0]}), 32'(held[31:0]));
    if (out_valid && ordy && q.size() > 0) begin
      e = q.pop_front();
      emitted++;
      chk("special", 32'(special), 32'(e.sp));
      chk("result", result, e.res);
      chk("flag_nv", 32'(flag_nv), 32'(e.nv));
    end
    hold_chk = out_valid && !ordy && !fl;
    held = {2'b00, special, flag_nv, result[29:0]};
    acc = iv && in_ready;
    if (fl) q.delete();
    else if (acc) begin
      e = model(opv, rmv, xc, yc, zc);
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    cyc++;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_special", 32'(special), 32'(0));
    chk("rst_result", result, 32'h0);
    chk("rst_flag_nv", 32'(flag_nv), 32'(0));
    chk("rst_in_ready_hold", 32'(in_ready), 32'(0));
    rst = 1'b0; in_valid = 1'b0;
    q.delete();
    hold_chk = 1'b0;
  endtask

  function automatic vec_t mk(logic [1:0] o, logic [2:0] r, logic [4:0] x, logic [4:0] y,
                              logic [4:0] z, logic sp, logic [31:0] res, logic nv);
    vec_t v;
    v.op = o; v.rm = r; v.x = x; v.y = y; v.z = z; v.sp = sp; v.res = res; v.nv = nv;
    return v;
  endfunction

  function automatic logic [4:0] rand_cls();
    logic [4:0] c;
    int unsigned k = $urandom_range(0, 7);
    logic s = 1'($urandom_range(0, 1));
    case (k)
      0, 1, 2: c = 5'b00000;
      3:       c = 5'b01000;
      4, 5:    c = 5'b00100;
      6:       c = ($urandom_range(0, 1) == 1) ? C_QNAN : C_SNAN;
      default: c = 5'b01000;
    endcase
    c[4] = s;
    return c;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    logic a;
    int sent;
    logic blocked;

    tbl[0]  = mk(2'b00, 3'b000, C_PINF, C_PZ,   C_POS,  1, QNAN,         1);
    tbl[1]  = mk(2'b00, 3'b000, C_PZ,   C_POS,  C_NZ,   1, 32'h0,        0);
    tbl[2]  = mk(2'b00, 3'b010, C_PZ,   C_POS,  C_NZ,   1, 32'h8000_0000,0);
    tbl[3]  = mk(2'b01, 3'b000, C_PZ,   C_POS,  C_NZ,   1, 32'h0,        0);
    tbl[4]  = mk(2'b01, 3'b000, C_PINF, C_POS,  C_PINF, 1, QNAN,         1);
    tbl[5]  = mk(2'b00, 3'b000, C_PINF, C_POS,  C_PINF, 1, 32'h7F80_0000,0);
    tbl[6]  = mk(2'b10, 3'b000, C_PINF, C_POS,  C_NINF, 1, 32'hFF80_0000,0);
    tbl[7]  = mk(2'b00, 3'b000, C_POS,  C_POS,  C_POS,  0, 32'h0,        0);
    tbl[8]  = mk(2'b00, 3'b000, C_POS,  C_POS,  C_SNAN, 1, QNAN,         1);
    tbl[9]  = mk(2'b00, 3'b000, C_POS,  C_QNAN, C_POS,  1, QNAN,         0);
    tbl[10] = mk(2'b00, 3'b000, C_PZ,   C_PINF, C_QNAN, 1, QNAN,         1);
    tbl[11] = mk(2'b00, 3'b000, C_POS,  C_POS,  C_NINF, 1, 32'hFF80_0000,0);
    tbl[12] = mk(2'b01, 3'b000, C_POS,  C_POS,  C_NINF, 1, 32'h7F80_0000,0);
    tbl[13] = mk(2'b11, 3'b010, C_NZ,   C_POS,  C_PZ,   1, 32'h8000_0000,0);
    tbl[14] = mk(2'b11, 3'b000, C_NZ,   C_POS,  C_PZ,   1, 32'h0,        0);
    tbl[15] = mk(2'b10, 3'b000, C_POS,  C_NZ,   C_PZ,   1, 32'h0,        0);

    do_reset();

    // Directed table, one operation at a time with out_ready high.
    for (int i = 0; i < 16; i++) begin
      opv = tbl[i].op; rmv = tbl[i].rm; xc = tbl[i].x; yc = tbl[i].y; zc = tbl[i].z;
      tick(1'b1, 1'b1, 1'b0, a);
      chk("tbl_accept", 32'(a), 32'(1));
      tick(1'b0, 1'b1, 1'b0, a);
      chk("tbl_out_valid", 32'(out_valid), 32'(1));
      chk("tbl_special", 32'(special), 32'(tbl[i].sp));
      chk("tbl_result", result, tbl[i].res);
      chk("tbl_flag_nv", 32'(flag_nv), 32'(tbl[i].nv));
      tick(1'b0, 1'b1, 1'b0, a);
    end

    // Backpressure: four back-to-back inputs, out_ready low in cycles 2..5.
    sent = 0; blocked = 1'b0;
    for (int c = 0; c < 14; c++) begin
      opv = 2'(sent); rmv = 3'b010;
      xc = (sent[0]) ? C_PINF : C_PZ; yc = C_POS; zc = (sent[1]) ? C_NINF : C_NZ;
      if (sent < 4 && !in_ready) blocked = 1'b1;
      tick(sent < 4, !(c >= 2 && c <= 5), 1'b0, a);
      if (a) sent++;
    end
    chk("bp_sent", 32'(sent), 32'(4));
    chk("bp_blocked", 32'(blocked), 32'(1));
    chk("bp_drained", 32'(q.size()), 32'(0));

    // Flush with two entries in flight.
    opv = 2'b00; rmv = 3'b000; xc = C_PINF; yc = C_POS; zc = C_POS;
    tick(1'b1, 1'b0, 1'b0, a);
    tick(1'b1, 1'b0, 1'b0, a);
    chk("fl_two_in_flight", 32'(q.size()), 32'(2));
    tick(1'b1, 1'b0, 1'b1, a);
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b1, 1'b0, a);

    // Reset with two entries in flight.
    tick(1'b1, 1'b0, 1'b0, a);
    tick(1'b1, 1'b0, 1'b0, a);
    do_reset();
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b1, 1'b0, a);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      opv = 2'($urandom_range(0, 3));
      rmv = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'($urandom_range(0, 7));
      xc = rand_cls(); yc = rand_cls(); zc = rand_cls();
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, a);
    end
    for (int c = 0; c < 6; c++) tick(1'b0, 1'b1, 1'b0, a);
    chk("final_drained", 32'(q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/fpu_fma_special.md
FPU_FMA_SPECIAL -- requirements
Module: fpu_fma_special

Interface
REQ-001 SHALL have a single clock, clk; all state updates on its rising edge.
REQ-002 SHALL have rst, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have in_valid, input, 1: operand set presented.
REQ-004 SHALL have in_ready, output, 1: operand set accepted when in_valid & in_ready.
REQ-005 SHALL have op, input, 2: 00 FMADD, 01 FMSUB, 10 FNMSUB, 11 FNMADD.
REQ-006 SHALL have rm, input, 3: RISC-V rounding mode; 010 = RDN.
REQ-007 SHALL have xs, x_zero, x_inf, x_nan, x_snan, input, 1 each: X class from the operand classifier; same five for Y (ys, y_*) and Z (zs, z_*).
REQ-008 SHALL have flush, input, 1: discard all in-flight entries.
REQ-009 SHALL have out_valid, output, 1; out_ready, input, 1; transfer when both high.
REQ-010 SHALL have special, output, 1: result fully determined here, main FMA datapath result ignored.
REQ-011 SHALL have result, output, 32: IEEE-754 single result, valid when special=1, else 0.
REQ-012 SHALL have flag_nv, output, 1: invalid-operation exception.

Function
REQ-013 SHALL compute product sign ps = xs ^ ys ^ op[1], effective addend sign za = zs ^ (op==01 | op==11).
REQ-014 SHALL resolve in strict priority: (a) inf*0: x_inf&y_zero or x_zero&y_inf -> special, 0x7FC00000, nv=1.
REQ-015 (b) any NaN -> special, 0x7FC00000, nv = x_snan|y_snan|z_snan.
REQ-016 (c) product inf (x_inf|y_inf) & z_inf & ps!=za -> special, 0x7FC00000, nv=1.
REQ-017 (d) product inf -> special, {ps,8'hFF,23'h0}, nv=0.
REQ-018 (e) z_inf -> special, {za,8'hFF,23'h0}, nv=0.
REQ-019 (f) product zero (x_zero|y_zero) & z_zero -> special, sign = (ps==za) ? ps : (rm==010), remaining bits 0, nv=0.
REQ-020 (g) otherwise special=0, result=0, nv=0.
REQ-021 SHALL be a two-stage pipeline: stage 1 registers the priority case code, ps, za, rm-derived zero sign; stage 2 registers special/result/flag_nv.
REQ-022 SHALL deliver out_valid exactly 2 cycles after acceptance when out_ready held high; throughput one per cycle.
REQ-023 SHALL advance: adv2 = !out_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1 & !rst.
REQ-024 SHALL hold out_valid, special, result, flag_nv stable while out_valid & !out_ready.
REQ-025 SHALL hold the stage-1 entry when stage 2 stalls; no entry dropped or duplicated under any out_ready pattern.
REQ-026 SHALL, on flush, clear s1_valid and out_valid next cycle; an input accepted in the flush cycle is discarded; flush overrides in_valid.
REQ-027 SHALL keep in_ready combinational from out_ready (no register), no path from in_valid to in_ready.

Reset
REQ-028 SHALL on rst clear s1_valid, out_valid, special, flag_nv to 0 and result to 32'h0 on the next edge.
REQ-029 SHALL drive in_ready=0 while rst high; entries in flight at reset are lost, not emitted.
REQ-030 SHALL give rst priority over flush and handshake.

Verification
REQ-031 inf*0: X=+inf (x_inf=1), Y=+0, Z=1.0, op=00, out_ready=1 -> 2 cycles later out_valid=1, special=1, result=0x7FC00000, flag_nv=1.
REQ-032 Zero sign: X=+0, Y=+1, Z=-0, op=00: rm=000 -> 0x00000000; rm=010 -> 0x80000000; op=01 with Z=-0, rm=000 -> 0x00000000, nv=0.
REQ-033 Inf cancel: X=+inf, Y=+1, Z=+inf, op=01 -> 0x7FC00000, nv=1; op=00 -> 0x7F800000, nv=0; op=10 with Z=-inf -> 0xFF800000.
REQ-034 Backpressure: 4 back-to-back inputs, out_ready low cycles 2-5 -> in_ready falls once both stages full, all 4 outputs emitted in order, values unchanged while stalled.
REQ-035 Flush/reset mid-flight: 2 entries in pipe, flush=1 one cycle -> out_valid=0 next cycle, nothing emitted; repeat with rst -> all outputs 0, in_ready=0 during rst.
REQ-036 Non-special: X=1.0, Y=2.0, Z=3.0 finite -> special=0, result=0, nv=0; sNaN in Z only -> 0x7FC00000, nv=1.
